// File: rtl/dct_transpose_buf_if.sv
// ============================================================================
// Module      : dct_transpose_buf_if
// Description : Row-in / column-out handshake bundle for dct_transpose_buf.
//               out_last exists only when DCT_TPOSE_LAST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dct_transpose_buf_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
`ifdef DCT_TPOSE_LAST_EN
    logic         out_last;
`endif

    // Buffer side.
    modport slave (
        input  in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
`ifdef DCT_TPOSE_LAST_EN
        output out_last,
`endif
        output in_ready, out_valid,
               out0, out1, out2, out3, out4, out5, out6, out7
    );

    // Row producer / column consumer side.
    modport master (
        output in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
`ifdef DCT_TPOSE_LAST_EN
        input  out_last,
`endif
        input  in_ready, out_valid,
               out0, out1, out2, out3, out4, out5, out6, out7
    );
endinterface

`default_nettype wire

// File: rtl/dct_transpose_buf.sv
// ============================================================================
// Module      : dct_transpose_buf
// Description : Ping-pong 8x8 transpose buffer: rows in, columns out, two
//               banks so one block fills while the other drains.
//               Optional macro DCT_TPOSE_LAST_EN adds out_last (column 7).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_transpose_buf #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dct_transpose_buf_if.slave    bus
);

    localparam logic [2:0] c_LAST_IDX = 3'd7;

    logic [W-1:0] r_bank [2][8][8];

    logic         r_wr_sel;
    logic         r_rd_sel;
    logic [2:0]   r_wr_row;
    logic [2:0]   r_rd_col;
    logic [1:0]   r_full;
    logic [1:0]   w_full_nxt;

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_wr_fire;
    logic         w_rd_fire;
    logic [W-1:0] w_in  [8];
    logic [W-1:0] w_out [8];

    assign w_in[0] = bus.in0;
    assign w_in[1] = bus.in1;
    assign w_in[2] = bus.in2;
    assign w_in[3] = bus.in3;
    assign w_in[4] = bus.in4;
    assign w_in[5] = bus.in5;
    assign w_in[6] = bus.in6;
    assign w_in[7] = bus.in7;

    // Handshake flags come straight from registers, never from in_valid/out_ready.
    assign w_in_ready  = ~r_full[r_wr_sel];
    assign w_out_valid = r_full[r_rd_sel];
    assign w_wr_fire   = bus.in_valid & w_in_ready;
    assign w_rd_fire   = w_out_valid & bus.out_ready;

    // Set and clear always target different banks, so both may apply at once.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_fire && (r_wr_row == c_LAST_IDX)) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
        if (w_rd_fire && (r_rd_col == c_LAST_IDX)) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
    end

    // Sample storage carries no reset; only the control state does.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int c = 0; c < 8; c++) begin
                r_bank[r_wr_sel][r_wr_row][c] <= w_in[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_wr_row <= 3'd0;
            r_rd_col <= 3'd0;
            r_full   <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_fire) begin
                r_wr_row <= r_wr_row + 3'd1;
                if (r_wr_row == c_LAST_IDX) begin
                    r_wr_sel <= ~r_wr_sel;
                end
            end
            if (w_rd_fire) begin
                r_rd_col <= r_rd_col + 3'd1;
                if (r_rd_col == c_LAST_IDX) begin
                    r_rd_sel <= ~r_rd_sel;
                end
            end
        end
    end

    // Column read: row index k of the draining bank at the current column.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_out[k] = w_out_valid ? r_bank[r_rd_sel][k][r_rd_col] : '0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out0      = w_out[0];
    assign bus.out1      = w_out[1];
    assign bus.out2      = w_out[2];
    assign bus.out3      = w_out[3];
    assign bus.out4      = w_out[4];
    assign bus.out5      = w_out[5];
    assign bus.out6      = w_out[6];
    assign bus.out7      = w_out[7];

`ifdef DCT_TPOSE_LAST_EN
    assign bus.out_last  = w_out_valid & (r_rd_col == c_LAST_IDX);
`endif

endmodule

`default_nettype wire
